avmm_arbiter: RTL and testbench

AVMM_ARBITER -- requirements
Module: avmm_arbiter

---
 rtl/avmm_arbiter.sv | 134 +++++++++++++
 tb/tb_avmm_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/avmm_arbiter.sv
// Two-requester Avalon-MM arbiter: round-robin grant onto one shared slave,
// single-cycle command issue, fixed-latency read return to the granted requester.
module avmm_arbiter #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  m0_address,
   input  logic        m0_write,
   input  logic        m0_read,
   input  logic [31:0] m0_writedata,
   output logic        m0_waitrequest,
   output logic        m0_readdatavalid,
   output logic [31:0] m0_readdata,
   input  logic [7:0]  m1_address,
   input  logic        m1_write,
   input  logic        m1_read,
   input  logic [31:0] m1_writedata,
   output logic        m1_waitrequest,
   output logic        m1_readdatavalid,
   output logic [31:0] m1_readdata,
   output logic [7:0]  s_address,
   output logic        s_write,
   output logic        s_read,
   output logic [31:0] s_writedata,
   input  logic [31:0] s_readdata
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_RD_WAIT = 2'd2;
   localparam logic [3:0] CNT_LAST  = 4'(READ_LATENCY - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic        is_wr_q, is_wr_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rdv0_q, rdv0_d;
   logic        rdv1_q, rdv1_d;

   logic req0, req1, win, issue;

   assign req0  = m0_read | m0_write;
   assign req1  = m1_read | m1_write;
   // On a tie the requester that did not win last time takes the bus.
   assign win   = (req0 & req1) ? ~last_q : req1;
   assign issue = (state_q == S_ISSUE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      is_wr_d = is_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rdv0_d  = 1'b0;
      rdv1_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 | req1) begin
               gnt_d   = win;
               last_d  = win;
               addr_d  = win ? m1_address : m0_address;
               wdata_d = win ? m1_writedata : m0_writedata;
               // Read and write together is treated as a write.
               is_wr_d = win ? m1_write : m0_write;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = 4'd0;
            state_d = is_wr_q ? S_IDLE : S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               rdata_d = s_readdata;
               rdv0_d  = ~gnt_q;
               rdv1_d  = gnt_q;
               cnt_d   = 4'd0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         is_wr_q <= 1'b0;
         rdata_q <= 32'd0;
         rdv0_q  <= 1'b0;
         rdv1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         is_wr_q <= is_wr_d;
         rdata_q <= rdata_d;
         rdv0_q  <= rdv0_d;
         rdv1_q  <= rdv1_d;
      end
   end

   // Command payload is only visible during ISSUE, so it needs no reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
   end

   assign s_write          = issue & is_wr_q;
   assign s_read           = issue & ~is_wr_q;
   assign s_address        = issue ? addr_q : 8'd0;
   assign s_writedata      = issue ? wdata_q : 32'd0;
   assign m0_waitrequest   = ~(issue & ~gnt_q);
   assign m1_waitrequest   = ~(issue & gnt_q);
   assign m0_readdatavalid = rdv0_q;
   assign m1_readdatavalid = rdv1_q;
   assign m0_readdata      = rdata_q;
   assign m1_readdata      = rdata_q;

endmodule

// File: tb/tb_avmm_arbiter.sv
// Scoreboard bench for avmm_arbiter: stimulus pushes expected slave commands and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_avmm_arbiter;
   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  m0_address, m1_address;
   logic        m0_write, m0_read, m1_write, m1_read;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [7:0]  s_address;
   logic        s_write, s_read;
   logic [31:0] s_writedata;
   logic [31:0] s_readdata;

   avmm_arbiter #(.READ_LATENCY(RL)) dut (
      .clk(clk), .rst(rst),
      .m0_address(m0_address), .m0_write(m0_write), .m0_read(m0_read),
      .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
      .m0_readdatavalid(m0_readdatavalid), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_write(m1_write), .m1_read(m1_read),
      .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
      .m1_readdatavalid(m1_readdatavalid), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_write(s_write), .s_read(s_read),
      .s_writedata(s_writedata), .s_readdata(s_readdata)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rd;
      logic [7:0]  addr;
      logic [31:0] data;
      logic        gnt;
   } slv_t;
   typedef struct packed {
      logic        idx;
      logic [31:0] data;
   } rd_t;

   slv_t exp_slv[$];
   rd_t  exp_rd[$];
   int   rd_cyc[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   bit   mon_en = 1'b0;

   // Slave model: data is valid only in the cycle READ_LATENCY after s_read.
   logic [31:0] mem [256];
   logic [15:0] rv_pipe = '0;
   logic [7:0]  ra_pipe [16];

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
      mem[8'h04] = 32'h12345678;
      for (int i = 0; i < 16; i++) ra_pipe[i] = 8'd0;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      rv_pipe <= {rv_pipe[14:0], s_read};
      ra_pipe[0] <= s_address;
      for (int i = 1; i < 16; i++) ra_pipe[i] <= ra_pipe[i-1];
   end

   always_comb begin
      s_readdata = 32'hBAD0BAD0;
      if (rv_pipe[RL-1]) s_readdata = mem[ra_pipe[RL-1]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : mon
      slv_t e;
      rd_t  r;
      int   c;
      if (rst) begin
         rd_cyc.delete();
      end else if (mon_en) begin
         if (s_write | s_read) begin
            if (exp_slv.size() == 0) begin
               chk("unexpected_slave_cmd", 32'(s_address), 32'hFFFF);
            end else begin
               e = exp_slv.pop_front();
               chk("s_read", 32'(s_read), 32'(e.rd));
               chk("s_write", 32'(s_write), 32'(!e.rd));
               chk("s_address", 32'(s_address), 32'(e.addr));
               if (!e.rd) chk("s_writedata", s_writedata, e.data);
               chk("grant_wait", 32'({m1_waitrequest, m0_waitrequest}),
                   e.gnt ? 32'd1 : 32'd2);
               if (s_read) rd_cyc.push_back(cyc);
            end
         end else begin
            chk("idle_wait", 32'({m1_waitrequest, m0_waitrequest}), 32'd3);
            chk("idle_addr", 32'(s_address), 32'd0);
            chk("idle_wdata", s_writedata, 32'd0);
         end
         if (m0_readdatavalid | m1_readdatavalid) begin
            if (exp_rd.size() == 0) begin
               chk("unexpected_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
            end else begin
               r = exp_rd.pop_front();
               chk("rdv_sel", 32'({m1_readdatavalid, m0_readdatavalid}),
                   r.idx ? 32'd2 : 32'd1);
               chk("m0_readdata", m0_readdata, r.data);
               chk("m1_readdata", m1_readdata, r.data);
               if (rd_cyc.size() == 0) begin
                  chk("rdv_without_issue", 32'd1, 32'd0);
               end else begin
                  c = rd_cyc.pop_front();
                  chk("rdv_latency", 32'(cyc), 32'(c + RL + 1));
               end
            end
         end
      end
   end

   task automatic set_req(input bit idx, input logic rd, input logic wr,
                          input logic [7:0] addr, input logic [31:0] data);
      if (idx == 1'b0) begin
         m0_read = rd; m0_write = wr; m0_address = addr; m0_writedata = data;
      end else begin
         m1_read = rd; m1_write = wr; m1_address = addr; m1_writedata = data;
      end
   endtask

   task automatic do_req(input bit idx, input logic rd, input logic wr,
                         input logic [7:0] addr, input logic [31:0] data,
                         input int exp_wait, input string name);
      int waits = 0;
      bit done = 1'b0;
      set_req(idx, rd, wr, addr, data);
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if ((idx ? m1_waitrequest : m0_waitrequest) == 1'b0) done = 1'b1;
         else waits++;
      end
      if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
      else if (exp_wait >= 0) chk({name, "_wait"}, 32'(waits), 32'(exp_wait));
      @(posedge clk);
      #1;
      set_req(idx, 1'b0, 1'b0, 8'd0, 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      set_req(1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      set_req(1'b1, 1'b0, 1'b0, 8'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Post-reset quiescent state
      @(negedge clk);
      chk("rst_m0_wait", 32'(m0_waitrequest), 32'd1);
      chk("rst_m1_wait", 32'(m1_waitrequest), 32'd1);
      chk("rst_s_write", 32'(s_write), 32'd0);
      chk("rst_s_read", 32'(s_read), 32'd0);
      chk("rst_rdv", 32'({m1_readdatavalid, m0_readdatavalid}), 32'd0);
      chk("rst_m0_rdata", m0_readdata, 32'd0);
      chk("rst_m1_rdata", m1_readdata, 32'd0);
      @(posedge clk);
      #1 mon_en = 1'b1;

      // Single m0 write
      exp_slv.push_back('{rd: 1'b0, addr: 8'h10, data: 32'hDEADBEEF, gnt: 1'b0});
      do_req(1'b0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 1, "wr_m0");

      // m1 read with latency 2
      exp_slv.push_back('{rd: 1'b1, addr: 8'h04, data: 32'd0, gnt: 1'b1});
      exp_rd.push_back('{idx: 1'b1, data: 32'h12345678});
      do_req(1'b1, 1'b1, 1'b0, 8'h04, 32'd0, 1, "rd_m1");
      idle(4);

      // Back-to-back m0 reads: second waits READ_LATENCY+1 cycles
      exp_slv.push_back('{rd: 1'b1, addr: 8'h08, data: 32'd0, gnt: 1'b0});
      exp_slv.push_back('{rd: 1'b1, addr: 8'h0C, data: 32'd0, gnt: 1'b0});
      exp_rd.push_back('{idx: 1'b0, data: 32'hC0DE0008});
      exp_rd.push_back('{idx: 1'b0, data: 32'hC0DE000C});
      do_req(1'b0, 1'b1, 1'b0, 8'h08, 32'd0, 1, "rd_m0_a");
      do_req(1'b0, 1'b1, 1'b0, 8'h0C, 32'd0, RL + 1, "rd_m0_b");
      idle(5);

      // Fresh reset, then both requesters write continuously
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_slv.push_back('{rd: 1'b0, addr: 8'h40, data: 32'hA, gnt: 1'b0});
      exp_slv.push_back('{rd: 1'b0, addr: 8'h41, data: 32'hB, gnt: 1'b1});
      exp_slv.push_back('{rd: 1'b0, addr: 8'h40, data: 32'hA, gnt: 1'b0});
      exp_slv.push_back('{rd: 1'b0, addr: 8'h41, data: 32'hB, gnt: 1'b1});
      fork
         begin
            do_req(1'b0, 1'b0, 1'b1, 8'h40, 32'hA, -1, "rr_m0_1");
            do_req(1'b0, 1'b0, 1'b1, 8'h40, 32'hA, -1, "rr_m0_2");
         end
         begin
            do_req(1'b1, 1'b0, 1'b1, 8'h41, 32'hB, -1, "rr_m1_1");
            do_req(1'b1, 1'b0, 1'b1, 8'h41, 32'hB, -1, "rr_m1_2");
         end
      join
      idle(2);

      // Reset during RD_WAIT aborts the read with no valid pulse
      exp_slv.push_back('{rd: 1'b1, addr: 8'h20, data: 32'd0, gnt: 1'b0});
      do_req(1'b0, 1'b1, 1'b0, 8'h20, 32'd0, 1, "rd_abort");
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      idle(4);
      chk("abort_rdata_kept_clear", m0_readdata, 32'd0);
      exp_slv.push_back('{rd: 1'b1, addr: 8'h30, data: 32'd0, gnt: 1'b0});
      exp_rd.push_back('{idx: 1'b0, data: 32'hC0DE0030});
      do_req(1'b0, 1'b1, 1'b0, 8'h30, 32'd0, 1, "rd_after_abort");
      idle(4);

      // Read and write together is issued as a write only
      exp_slv.push_back('{rd: 1'b0, addr: 8'h50, data: 32'h55, gnt: 1'b0});
      do_req(1'b0, 1'b1, 1'b1, 8'h50, 32'h55, 1, "rw_m0");
      idle(6);

      chk("slv_queue_empty", 32'(exp_slv.size()), 32'd0);
      chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
